// File: rtl/rst_done_mon.sv
// Qualifies sys/mac/phy reset release and init-done, then declares ready or issues bounded re-reset requests.
// Inputs pass a 2-cycle synchronizer before any decision; no backpressure. RST_DONE_MON_STATUS_EN adds o_dom_fail.
module rst_done_mon #(
  parameter int TIMEOUT_W  = 16,
  parameter int STABLE_CYC = 8,
  parameter int REQ_CYC    = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic       src_clk,
  input  logic       arstn,
  input  logic       i_rstn_sys,
  input  logic       i_rstn_mac,
  input  logic       i_rstn_phy,
  input  logic       i_done_sys,
  input  logic       i_done_mac,
  input  logic       i_done_phy,
  output logic       o_sys_ready,
  output logic       o_rst_req,
  output logic       o_err_lock,
  output logic [3:0] o_retry_cnt
`ifdef RST_DONE_MON_STATUS_EN
  ,
  output logic [2:0] o_dom_fail
`endif
);

  typedef enum logic [2:0] {
    ST_WAIT_RST,
    ST_WAIT_DONE,
    ST_STABLE,
    ST_READY,
    ST_FAULT,
    ST_LOCK
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [7:0]           STB_LAST  = 8'(STABLE_CYC - 1);
  localparam logic [7:0]           REQ_LAST  = 8'(REQ_CYC - 1);
  localparam logic [3:0]           RETRY_MAX = 4'(MAX_RETRY);

  logic [5:0]           w_async_in;
  logic [5:0]           r_sync1;
  logic [5:0]           r_sync2;
  logic                 w_rstn_all;
  logic                 w_done_all;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic [TIMEOUT_W-1:0] w_tmo_nxt;
  logic [7:0]           r_stb_cnt;
  logic [7:0]           w_stb_nxt;
  logic [7:0]           r_req_cnt;
  logic [7:0]           w_req_nxt;
  logic [3:0]           r_retry_cnt;
  logic [3:0]           w_retry_nxt;
  logic                 w_tmo_hit;
  logic                 w_stb_done;
  logic                 w_fault_evt;

  assign w_async_in = {i_done_phy, i_done_mac, i_done_sys, i_rstn_phy, i_rstn_mac, i_rstn_sys};

  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_async_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rstn_all = &r_sync2[2:0];
  assign w_done_all = &r_sync2[5:3];

  // Both fire on the edge the counter would reach its terminal value.
  assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
  assign w_stb_done = w_done_all && (r_stb_cnt == STB_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    w_stb_nxt   = r_stb_cnt;
    w_req_nxt   = r_req_cnt;
    w_retry_nxt = r_retry_cnt;
    w_fault_evt = 1'b0;
    case (r_state)
      ST_WAIT_RST: begin
        w_tmo_nxt = '0;
        w_stb_nxt = '0;
        if (w_rstn_all) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        w_tmo_nxt = r_tmo_cnt + TIMEOUT_W'(1);
        if (!w_rstn_all) begin
          w_state_nxt = ST_WAIT_RST;
          w_tmo_nxt   = '0;
          w_stb_nxt   = '0;
        end else if (w_done_all) begin
          w_stb_nxt   = 8'd1;
          w_state_nxt = w_stb_done ? ST_READY : ST_STABLE;
        end else if (w_tmo_hit) begin
          w_fault_evt = 1'b1;
        end
      end
      ST_STABLE: begin
        w_tmo_nxt = r_tmo_cnt + TIMEOUT_W'(1);
        if (!w_rstn_all) begin
          w_state_nxt = ST_WAIT_RST;
          w_tmo_nxt   = '0;
          w_stb_nxt   = '0;
        end else if (w_stb_done) begin
          w_state_nxt = ST_READY;
          w_stb_nxt   = '0;
        end else if (w_tmo_hit) begin
          w_fault_evt = 1'b1;
        end else if (!w_done_all) begin
          w_state_nxt = ST_WAIT_DONE;
          w_stb_nxt   = '0;
        end else begin
          w_stb_nxt = r_stb_cnt + 8'd1;
        end
      end
      ST_READY: begin
        if (!w_rstn_all) begin
          w_state_nxt = ST_WAIT_RST;
          w_tmo_nxt   = '0;
          w_stb_nxt   = '0;
        end else if (!w_done_all) begin
          w_state_nxt = ST_WAIT_DONE;
          w_tmo_nxt   = '0;
          w_stb_nxt   = '0;
        end
      end
      ST_FAULT: begin
        w_req_nxt = r_req_cnt + 8'd1;
        if (r_req_cnt == REQ_LAST) begin
          w_state_nxt = ST_WAIT_RST;
          w_req_nxt   = '0;
          w_tmo_nxt   = '0;
          w_stb_nxt   = '0;
        end
      end
      ST_LOCK: begin
        w_state_nxt = ST_LOCK;
      end
      default: begin
        w_state_nxt = ST_WAIT_RST;
      end
    endcase

    // Retry budget is decided at the timeout itself; an exhausted budget never pulses rst_req.
    if (w_fault_evt) begin
      w_tmo_nxt = '0;
      w_stb_nxt = '0;
      w_req_nxt = '0;
      if (r_retry_cnt < RETRY_MAX) begin
        w_state_nxt = ST_FAULT;
        w_retry_nxt = (r_retry_cnt == 4'hF) ? r_retry_cnt : r_retry_cnt + 4'd1;
      end else begin
        w_state_nxt = ST_LOCK;
      end
    end
  end

  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= ST_WAIT_RST;
      r_tmo_cnt   <= '0;
      r_stb_cnt   <= '0;
      r_req_cnt   <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_stb_cnt   <= w_stb_nxt;
      r_req_cnt   <= w_req_nxt;
      r_retry_cnt <= w_retry_nxt;
    end
  end

`ifdef RST_DONE_MON_STATUS_EN
  logic [2:0] r_dom_fail;

  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      r_dom_fail <= '0;
    end else if (w_fault_evt) begin
      r_dom_fail <= ~r_sync2[5:3];
    end
  end

  assign o_dom_fail = r_dom_fail;
`endif

  assign o_sys_ready = (r_state == ST_READY);
  assign o_rst_req   = (r_state == ST_FAULT);
  assign o_err_lock  = (r_state == ST_LOCK);
  assign o_retry_cnt = r_retry_cnt;

endmodule

// File: doc/rst_done_mon.md
Name: rst_done_mon

Overview:
- Receiving end of the reset-release sequence.
- Watches the released domain resets (sys/mac/phy) and each domain's init-done flag, and declares the system ready once all domains report done and stay stable.
- If a domain never reports done, requests a re-reset from the reset controller, up to a retry limit, then locks in error.
- Sits beside the reset controller in src_clk; drives top-level ready and status.

Parameters:
- TIMEOUT_W, 16: width of the done-wait timeout counter. Timeout fires when the counter reaches 2^TIMEOUT_W-1.
- STABLE_CYC, 8: consecutive src_clk cycles during which all done flags must be high before ready asserts (range 1..255).
- REQ_CYC, 16: length in cycles of the rst_req pulse (range 1..255).
- MAX_RETRY, 3: number of re-reset requests before lock-out (range 1..15).

Ports:
- src_clk, in, 1: monitor clock.
- arstn, in, 1: asynchronous active-low reset.
- rstn_sys, in, 1: released sys reset. Asynchronous to src_clk; 2FF-synchronized.
- rstn_mac, in, 1: released mac reset. 2FF-synchronized.
- rstn_phy, in, 1: released phy reset. 2FF-synchronized.
- done_sys, in, 1: sys-domain init done (level). 2FF-synchronized.
- done_mac, in, 1: mac-domain init done. 2FF-synchronized.
- done_phy, in, 1: phy-domain init done. 2FF-synchronized.
- sys_ready, out, 1: all domains up and stable.
- rst_req, out, 1: re-reset request to the reset controller, held for REQ_CYC cycles.
- err_lock, out, 1: retries exhausted.
- retry_cnt, out, 4: number of re-reset requests issued.

Behaviour:
- Reset is decided: arstn is asynchronous, active-low; clock is src_clk. All flops, including synchronizer stages, clear to 0 on arstn low.
- Reset values of outputs: sys_ready=0, rst_req=0, err_lock=0, retry_cnt=0. State is WAIT_RST.
- "rstn_all" means the AND of the three synchronized rstn. "done_all" means the AND of the three synchronized done flags.
- Input-to-decision latency is 2 cycles (synchronizer depth).
- State machine transitions (registered; outputs derived from registered state and counters):
  - WAIT_RST: timeout counter and stable counter are held at 0. Go to WAIT_DONE when rstn_all=1.
  - WAIT_DONE: timeout counter increments every cycle.
    - If done_all=1, go to STABLE with the stable counter at 1.
    - Else, if the timeout counter reaches its maximum, go to FAULT.
    - If rstn_all drops, go to WAIT_RST and clear the counters.
  - STABLE: stable counter increments while done_all=1; timeout counter keeps running.
    - When the stable counter reaches STABLE_CYC, go to READY.
    - If done_all drops, go back to WAIT_DONE; the stable counter clears and the timeout counter is retained.
    - If the stable count completes in the same cycle the timeout fires, READY wins.
  - READY: sys_ready=1.
    - If rstn_all drops, go to WAIT_RST; sys_ready falls on the next clock edge.
    - If done_all drops without rstn dropping, go to WAIT_DONE with the timeout counter cleared.
    - retry_cnt is not cleared here.
  - FAULT: entered only from WAIT_DONE or STABLE.
    - If retry_cnt < MAX_RETRY: increment retry_cnt on entry (saturating at 15), assert rst_req for exactly REQ_CYC cycles, then go to WAIT_RST with the counters cleared.
    - If retry_cnt = MAX_RETRY: go to LOCK and do not assert rst_req.
  - LOCK: err_lock=1, sys_ready=0, rst_req=0. Only arstn exits this state.
- Glitch rule: a done or rstn deassertion shorter than one src_clk cycle may be missed. Any deassertion seen after the synchronizer is acted on.

Optional Feature:
- Macro: RST_DONE_MON_STATUS_EN.
- When defined, adds output dom_fail[2:0]. On each FAULT entry it latches {~done_phy_s, ~done_mac_s, ~done_sys_s}, i.e. which domains were missing at timeout. It is held until the next FAULT entry or arstn, and resets to 0.
- When not defined, the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Bench setting: TIMEOUT_W=6, STABLE_CYC=4, REQ_CYC=3, MAX_RETRY=2.
- Scenario 1: release all rstn, then raise all done 5 cycles later. Expected: sys_ready=1 exactly 2+4 cycles after done_all rises; rst_req stays 0; retry_cnt=0.
- Scenario 2: while in STABLE, drop done_mac for 1 cycle after 2 stable cycles. Expected: stable count restarts; sys_ready rises 4 cycles after done_mac is back, plus 2 cycles of synchronizer latency.
- Scenario 3: keep done_phy low. Expected: rst_req high for 3 cycles after 63 timeout cycles; retry_cnt=1; then back to WAIT_RST, waiting for rstn. With the macro defined, dom_fail=3'b100.
- Scenario 4: keep done_phy low across repeated rstn cycles. Expected: two rst_req pulses (retry_cnt=2); the third timeout produces err_lock=1 with no rst_req; subsequent done_all=1 is ignored until arstn.
- Scenario 5: in READY, pulse rstn_sys low for 2 cycles. Expected: sys_ready drops 3 cycles after rstn_sys falls (2 synchronizer cycles plus 1 registered cycle); it re-qualifies after the stable window.
- Scenario 6: assert arstn mid-rst_req pulse. Expected: all outputs go to 0 immediately (asynchronously); retry_cnt=0.
